// File: rtl/snitch_acc_offload_tracker_pkg.sv
// Shared constants and credit-update helper for the per-core accelerator offload tracker.
package snitch_acc_offload_tracker_pkg;

    localparam int unsigned AccAddrWidth = 32;
    localparam int unsigned AccOpWidth   = 32;

    typedef enum logic [1:0] {
        CreditHold,
        CreditInc,
        CreditDec
    } credit_op_e;

    // A decrement at zero is a spurious response; the counter saturates instead of wrapping.
    function automatic credit_op_e credit_op(input logic inc, input logic dec, input logic empty);
        if (inc && !dec) return CreditInc;
        if (dec && !inc && !empty) return CreditDec;
        return CreditHold;
    endfunction

endpackage

// File: rtl/snitch_acc_offload_tracker_fifo.sv
// Registered (non fall-through) request queue; output is valid the cycle after a push.
module snitch_acc_offload_tracker_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  cnt_q;
    logic             do_push, do_pop;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= next_ptr(wr_ptr_q);
            end
            if (do_pop) rd_ptr_q <= next_ptr(rd_ptr_q);
            if (do_push && !do_pop) cnt_q <= cnt_q + 1'b1;
            else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/snitch_acc_offload_tracker.sv
// Per-core offload stage: queues accelerator requests, caps in-flight offloads with a
// credit counter and registers returning responses toward the core.
module snitch_acc_offload_tracker
    import snitch_acc_offload_tracker_pkg::*;
#(
    parameter int unsigned IdWidth        = 5,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned ReqDepth       = 2,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [AccAddrWidth-1:0]               core_qaddr_i,
    input  logic [IdWidth-1:0]                    core_qid_i,
    input  logic [AccOpWidth-1:0]                 core_qdata_op_i,
    input  logic [DataWidth-1:0]                  core_qdata_arga_i,
    input  logic [DataWidth-1:0]                  core_qdata_argb_i,
    input  logic [DataWidth-1:0]                  core_qdata_argc_i,
    input  logic                                  core_qvalid_i,
    output logic                                  core_qready_o,
    output logic [AccAddrWidth-1:0]               hive_qaddr_o,
    output logic [IdWidth-1:0]                    hive_qid_o,
    output logic [AccOpWidth-1:0]                 hive_qdata_op_o,
    output logic [DataWidth-1:0]                  hive_qdata_arga_o,
    output logic [DataWidth-1:0]                  hive_qdata_argb_o,
    output logic [DataWidth-1:0]                  hive_qdata_argc_o,
    output logic                                  hive_qvalid_o,
    input  logic                                  hive_qready_i,
    input  logic [DataWidth-1:0]                  hive_pdata_i,
    input  logic [IdWidth-1:0]                    hive_pid_i,
    input  logic                                  hive_perror_i,
    input  logic                                  hive_pvalid_i,
    output logic                                  hive_pready_o,
    output logic [DataWidth-1:0]                  core_pdata_o,
    output logic [IdWidth-1:0]                    core_pid_o,
    output logic                                  core_perror_o,
    output logic                                  core_pvalid_o,
    input  logic                                  core_pready_i,
    output logic [$clog2(MaxOutstanding+1)-1:0]   outstanding_o,
    output logic                                  underflow_o
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    typedef struct packed {
        logic [AccAddrWidth-1:0] addr;
        logic [IdWidth-1:0]      id;
        logic [AccOpWidth-1:0]   data_op;
        logic [DataWidth-1:0]    data_arga;
        logic [DataWidth-1:0]    data_argb;
        logic [DataWidth-1:0]    data_argc;
    } acc_req_t;

    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic [IdWidth-1:0]   id;
        logic                 error;
    } acc_rsp_t;

    localparam int unsigned ReqW = $bits(acc_req_t);

    acc_req_t        req_in, req_out;
    acc_rsp_t        rsp_q;
    logic            rsp_valid_q;
    logic [CntW-1:0] outstanding_q, outstanding_d;
    logic            underflow_q;
    logic            fifo_full, fifo_empty;
    logic            req_hs, rsp_in_hs, rsp_out_hs;

    assign req_in = '{addr: core_qaddr_i, id: core_qid_i, data_op: core_qdata_op_i,
                      data_arga: core_qdata_arga_i, data_argb: core_qdata_argb_i,
                      data_argc: core_qdata_argc_i};

    assign core_qready_o = !fifo_full && (outstanding_q < CntW'(MaxOutstanding));
    assign req_hs        = core_qvalid_i && core_qready_o;

    snitch_acc_offload_tracker_fifo #(
        .Width (ReqW),
        .Depth (ReqDepth)
    ) i_req_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (req_hs),
        .data_i  (req_in),
        .pop_i   (hive_qvalid_o && hive_qready_i),
        .data_o  (req_out),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign hive_qvalid_o     = !fifo_empty;
    assign hive_qaddr_o      = req_out.addr;
    assign hive_qid_o        = req_out.id;
    assign hive_qdata_op_o   = req_out.data_op;
    assign hive_qdata_arga_o = req_out.data_arga;
    assign hive_qdata_argb_o = req_out.data_argb;
    assign hive_qdata_argc_o = req_out.data_argc;

    // Single full register: a new response may enter in the same cycle the held one drains.
    assign hive_pready_o = !rsp_valid_q || core_pready_i;
    assign rsp_in_hs     = hive_pvalid_i && hive_pready_o;
    assign rsp_out_hs    = rsp_valid_q && core_pready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_q       <= '0;
            rsp_valid_q <= 1'b0;
        end else if (rsp_in_hs) begin
            rsp_q       <= '{data: hive_pdata_i, id: hive_pid_i, error: hive_perror_i};
            rsp_valid_q <= 1'b1;
        end else if (core_pready_i) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign core_pdata_o  = rsp_q.data;
    assign core_pid_o    = rsp_q.id;
    assign core_perror_o = rsp_q.error;
    assign core_pvalid_o = rsp_valid_q;

    always_comb begin
        outstanding_d = outstanding_q;
        unique case (credit_op(req_hs, rsp_out_hs, outstanding_q == '0))
            CreditInc: outstanding_d = outstanding_q + 1'b1;
            CreditDec: outstanding_d = outstanding_q - 1'b1;
            default:   outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            outstanding_q <= '0;
            underflow_q   <= 1'b0;
        end else begin
            outstanding_q <= outstanding_d;
            if (rsp_in_hs && (outstanding_q == '0) && !req_hs) underflow_q <= 1'b1;
        end
    end

    assign outstanding_o = outstanding_q;
    assign underflow_o   = underflow_q;

endmodule

// File: tb/tb_snitch_acc_offload_tracker.sv
// Randomized scoreboard bench for the offload tracker against a queue-based reference model.
module tb_snitch_acc_offload_tracker;

    localparam int unsigned IdW    = 5;
    localparam int unsigned DW     = 32;
    localparam int unsigned Depth  = 2;
    localparam int unsigned MaxOut = 4;
    localparam int unsigned CntW   = $clog2(MaxOut + 1);

    typedef struct packed {
        logic [31:0]    addr;
        logic [IdW-1:0] id;
        logic [31:0]    op;
        logic [DW-1:0]  a;
        logic [DW-1:0]  b;
        logic [DW-1:0]  c;
    } req_t;

    typedef struct packed {
        logic [DW-1:0]  data;
        logic [IdW-1:0] id;
        logic           err;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_i;
    req_t cur_req;
    logic core_qvalid_i, core_qready_o;
    logic [31:0] hive_qaddr_o, hive_qdata_op_o;
    logic [IdW-1:0] hive_qid_o, hive_pid_i, core_pid_o;
    logic [DW-1:0] hive_qdata_arga_o, hive_qdata_argb_o, hive_qdata_argc_o;
    logic hive_qvalid_o, hive_qready_i;
    logic [DW-1:0] hive_pdata_i, core_pdata_o;
    logic hive_perror_i, hive_pvalid_i, hive_pready_o;
    logic core_perror_o, core_pvalid_o, core_pready_i;
    logic [CntW-1:0] outstanding_o;
    logic underflow_o;

    always #5 clk = ~clk;

    snitch_acc_offload_tracker #(
        .IdWidth        (IdW),
        .DataWidth      (DW),
        .ReqDepth       (Depth),
        .MaxOutstanding (MaxOut)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .core_qaddr_i      (cur_req.addr),
        .core_qid_i        (cur_req.id),
        .core_qdata_op_i   (cur_req.op),
        .core_qdata_arga_i (cur_req.a),
        .core_qdata_argb_i (cur_req.b),
        .core_qdata_argc_i (cur_req.c),
        .core_qvalid_i     (core_qvalid_i),
        .core_qready_o     (core_qready_o),
        .hive_qaddr_o      (hive_qaddr_o),
        .hive_qid_o        (hive_qid_o),
        .hive_qdata_op_o   (hive_qdata_op_o),
        .hive_qdata_arga_o (hive_qdata_arga_o),
        .hive_qdata_argb_o (hive_qdata_argb_o),
        .hive_qdata_argc_o (hive_qdata_argc_o),
        .hive_qvalid_o     (hive_qvalid_o),
        .hive_qready_i     (hive_qready_i),
        .hive_pdata_i      (hive_pdata_i),
        .hive_pid_i        (hive_pid_i),
        .hive_perror_i     (hive_perror_i),
        .hive_pvalid_i     (hive_pvalid_i),
        .hive_pready_o     (hive_pready_o),
        .core_pdata_o      (core_pdata_o),
        .core_pid_o        (core_pid_o),
        .core_perror_o     (core_perror_o),
        .core_pvalid_o     (core_pvalid_o),
        .core_pready_i     (core_pready_i),
        .outstanding_o     (outstanding_o),
        .underflow_o       (underflow_o)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Reference state: requests accepted but not yet at the hive, responses owed to the core,
    // ids the hive may still answer, credit usage and the sticky underflow flag.
    req_t           mq[$];
    rsp_t           er[$];
    logic [IdW-1:0] pending[$];
    int unsigned    m_out = 0;
    bit             m_uf = 0;
    bit             mon_en = 0;
    bit             req_taken = 0;
    bit             hrsp_taken = 0;

    task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst_i) begin
            bit   exp_qready, exp_hpready, req_hs, rsp_in, rsp_out;
            req_t hq, popped_req;
            rsp_t cp, popped_rsp;
            exp_qready  = (mq.size() < Depth) && (m_out < MaxOut);
            exp_hpready = (er.size() == 0) || core_pready_i;
            rsp_out     = 1'b0;

            check("core_qready", core_qready_o, exp_qready);
            check("hive_qvalid", hive_qvalid_o, mq.size() != 0);
            hq = {hive_qaddr_o, hive_qid_o, hive_qdata_op_o,
                  hive_qdata_arga_o, hive_qdata_argb_o, hive_qdata_argc_o};
            if (hive_qvalid_o && mq.size() != 0) begin
                check("hive_req", hq, mq[0]);
                if (hive_qready_i) begin
                    popped_req = mq.pop_front();
                    pending.push_back(popped_req.id);
                end
            end

            check("core_pvalid", core_pvalid_o, er.size() != 0);
            check("hive_pready", hive_pready_o, exp_hpready);
            cp = {core_pdata_o, core_pid_o, core_perror_o};
            if (core_pvalid_o && er.size() != 0) begin
                check("core_rsp", cp, er[0]);
                if (core_pready_i) begin
                    popped_rsp = er.pop_front();
                    rsp_out    = 1'b1;
                end
            end

            check("outstanding", outstanding_o, m_out);
            check("underflow", underflow_o, m_uf);

            req_hs = core_qvalid_i && exp_qready;
            rsp_in = hive_pvalid_i && exp_hpready;
            if (rsp_in) er.push_back(rsp_t'({hive_pdata_i, hive_pid_i, hive_perror_i}));
            if (req_hs) mq.push_back(cur_req);
            if (rsp_in && m_out == 0 && !req_hs) m_uf = 1'b1;
            if (req_hs && !rsp_out) m_out++;
            else if (rsp_out && !req_hs && m_out != 0) m_out--;
            req_taken  = req_hs;
            hrsp_taken = rsp_in;
        end
    end

    task automatic new_req();
        cur_req.addr = $urandom;
        cur_req.id   = IdW'($urandom);
        cur_req.op   = $urandom;
        cur_req.a    = $urandom;
        cur_req.b    = $urandom;
        cur_req.c    = $urandom;
    endtask

    // One cycle of randomized stimulus; valids are held until their handshake completes.
    task automatic step(input int unsigned pqv, input int unsigned phq,
                        input int unsigned php, input int unsigned pcp);
        int unsigned k;
        @(posedge clk);
        #1;
        if (!core_qvalid_i || req_taken) begin
            core_qvalid_i = ($urandom_range(0, 99) < pqv);
            if (core_qvalid_i) new_req();
        end
        if (!hive_pvalid_i || hrsp_taken) begin
            hive_pvalid_i = 1'b0;
            if (pending.size() != 0 && $urandom_range(0, 99) < php) begin
                k = $urandom_range(0, pending.size() - 1);
                hive_pid_i = pending[k];
                pending.delete(k);
                case ($urandom_range(0, 3))
                    0:       hive_pdata_i = 32'hDEADBEEF;
                    1:       hive_pdata_i = 32'h1;
                    default: hive_pdata_i = $urandom;
                endcase
                hive_perror_i = $urandom_range(0, 1);
                hive_pvalid_i = 1'b1;
            end
        end
        hive_qready_i = ($urandom_range(0, 99) < phq);
        core_pready_i = ($urandom_range(0, 99) < pcp);
    endtask

    task automatic drain();
        int unsigned n = 0;
        while ((mq.size() != 0 || er.size() != 0 || pending.size() != 0 ||
                core_qvalid_i || hive_pvalid_i) && n < 400) begin
            step(0, 100, 100, 100);
            n++;
        end
        check("drain_done", n < 400, 1'b1);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_outstanding"}, outstanding_o, '0);
        check({tag, "_qready"}, core_qready_o, 1'b1);
        check({tag, "_hive_qvalid"}, hive_qvalid_o, 1'b0);
        check({tag, "_core_pvalid"}, core_pvalid_o, 1'b0);
        check({tag, "_core_p"}, {core_pdata_o, core_pid_o, core_perror_o}, '0);
        check({tag, "_hive_pready"}, hive_pready_o, 1'b1);
        check({tag, "_underflow"}, underflow_o, 1'b0);
    endtask

    task automatic clear_model();
        mq.delete();
        er.delete();
        pending.delete();
        m_out      = 0;
        m_uf       = 1'b0;
        req_taken  = 1'b0;
        hrsp_taken = 1'b0;
        core_qvalid_i = 1'b0;
        hive_pvalid_i = 1'b0;
        hive_qready_i = 1'b0;
        core_pready_i = 1'b0;
    endtask

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b0;
        cur_req = '0;
        hive_pdata_i = '0;
        hive_pid_i = '0;
        hive_perror_i = 1'b0;
        clear_model();
        #1 rst_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_checks("rst0");
        rst_i = 1'b0;
        mon_en = 1'b1;

        // Credit cap: no responses, hive always ready.
        repeat (12) step(100, 100, 0, 100);
        #1;
        check("cap_outstanding", outstanding_o, CntW'(MaxOut));
        check("cap_qready", core_qready_o, 1'b0);
        drain();

        // Queue full: hive stalls, queue fills to its depth.
        repeat (10) step(100, 0, 0, 100);
        #1;
        check("full_qready", core_qready_o, 1'b0);
        check("full_outstanding", outstanding_o, CntW'(Depth));
        drain();

        repeat (300) step(80, 70, 60, 30);
        repeat (200) step(100, 100, 100, 100);
        repeat (400) step(50, 50, 50, 50);

        // Asynchronous reset in the middle of traffic.
        repeat (37) step(80, 50, 50, 50);
        @(posedge clk);
        #3;
        rst_i = 1'b1;
        #1;
        reset_checks("rst_mid");
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;

        repeat (200) step(70, 60, 60, 60);
        drain();

        // Spurious response with nothing outstanding.
        @(posedge clk);
        #1;
        core_qvalid_i = 1'b0;
        hive_qready_i = 1'b1;
        core_pready_i = 1'b0;
        hive_pid_i    = IdW'(7);
        hive_perror_i = 1'b1;
        hive_pdata_i  = 32'hDEADBEEF;
        hive_pvalid_i = 1'b1;
        @(posedge clk);
        #1;
        hive_pvalid_i = 1'b0;
        check("uf_fwd_valid", core_pvalid_o, 1'b1);
        check("uf_fwd_id", core_pid_o, IdW'(7));
        check("uf_fwd_err", core_perror_o, 1'b1);
        check("uf_flag", underflow_o, 1'b1);
        core_pready_i = 1'b1;
        @(posedge clk);
        #1;
        check("uf_sticky", underflow_o, 1'b1);
        check("uf_outstanding", outstanding_o, '0);

        repeat (200) step(60, 60, 60, 60);
        drain();
        #1;
        check("uf_final", underflow_o, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
